// File: rtl/mod_lut_pkg.sv
// mod_lut_pkg
// Shared definitions for the modular-multiple lookup table:
//   - FSM state encoding (EMPTY / FILL / READY)
//   - LUT_W: widest entry the modular-add helper supports
//   - mod_add(): (a + b) mod m for a, b < m, by one conditional subtraction
package mod_lut_pkg;

    localparam int LUT_W = 64;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;

    // The sum carries one extra bit so a + b never wraps before the compare.
    // Callers zero-extend narrower operands; the result is < m, so it
    // truncates back to the caller's width without loss.
    function automatic logic [LUT_W-1:0] mod_add(
        input logic [LUT_W-1:0] a,
        input logic [LUT_W-1:0] b,
        input logic [LUT_W-1:0] m
    );
        logic [LUT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, m})
            s = s - {1'b0, m};
        return s[LUT_W-1:0];
    endfunction

endpackage

// File: rtl/mod_lut_ram.sv
// mod_lut_ram
// Table storage: one synchronous write port, NUM_CH registered read ports.
// Ports:
//   clk, rst_n        clock / async active-low reset (read registers only)
//   we, waddr, wdata  write port
//   re                per-channel read enable
//   raddr             channel c at [c*ADDR_W +: ADDR_W]
//   rdata             channel c at [c*DATA_W +: DATA_W]; holds when re[c]=0
module mod_lut_ram #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 49,
    parameter int NUM_CH = 2
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [NUM_CH-1:0]        re,
    input  logic [NUM_CH*ADDR_W-1:0] raddr,
    output logic [NUM_CH*DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    // Contents are deliberately not reset; validity is tracked by the FSM.
    (* ram_style = "distributed" *) logic [DATA_W-1:0] mem [DEPTH];

    logic [NUM_CH-1:0][DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (re[c])
                    r_rdata[c] <= mem[raddr[c*ADDR_W +: ADDR_W]];
            end
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/mod_const_lut.sv
// mod_const_lut
// Builds and serves a table entry[i] = (i*W) mod MODULUS, i = 0..2^ADDR_W-1.
// The table is filled one entry per cycle with a running modular
// accumulator (acc += W, conditional subtract), so no multiplier is needed.
// Ports:
//   clk, rst_n   clock / async active-low reset
//   cfg_valid    weight offered;  cfg_ready: weight can be taken (not in FILL)
//   cfg_weight   weight W;        cfg_err: one-cycle pulse, W >= MODULUS
//   init_done    table valid
//   rd_en        per-channel read request (honoured only in READY)
//   rd_addr      channel c at [c*ADDR_W +: ADDR_W]
//   rd_data      channel c at [c*DATA_W +: DATA_W], one cycle after rd_en
//   rd_valid     per-channel read-data valid
module mod_const_lut
    import mod_lut_pkg::*;
#(
    parameter int                ADDR_W  = 5,
    parameter int                DATA_W  = 49,
    parameter int                NUM_CH  = 2,
    parameter logic [DATA_W-1:0] MODULUS = DATA_W'(64'd549824583172097)
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [DATA_W-1:0]        cfg_weight,
    output logic                     cfg_err,
    output logic                     init_done,
    input  logic [NUM_CH-1:0]        rd_en,
    input  logic [NUM_CH*ADDR_W-1:0] rd_addr,
    output logic [NUM_CH*DATA_W-1:0] rd_data,
    output logic [NUM_CH-1:0]        rd_valid
);

    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_w;
    logic [DATA_W-1:0] r_acc;
    logic [ADDR_W-1:0] r_idx;
    logic              r_init_done;
    logic              r_cfg_err;
    logic [NUM_CH-1:0] r_rd_valid;

    logic              w_accept;
    logic              w_w_ok;
    logic              w_we;
    logic [NUM_CH-1:0] w_re;
    logic [DATA_W-1:0] w_acc_nxt;

    assign cfg_ready = (r_state != ST_FILL);
    assign w_accept  = cfg_valid & cfg_ready;
    assign w_w_ok    = (cfg_weight < MODULUS);
    assign w_we      = (r_state == ST_FILL);
    // Reads are gated by the state before the edge, so a read on the same
    // edge that accepts a new weight still sees the old table.
    assign w_re      = rd_en & {NUM_CH{r_state == ST_READY}};

    // r_acc and r_w are both < MODULUS, so the helper's single conditional
    // subtraction fully reduces the sum.
    assign w_acc_nxt = DATA_W'(mod_add(LUT_W'(r_acc), LUT_W'(r_w), LUT_W'(MODULUS)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_w         <= '0;
            r_acc       <= '0;
            r_idx       <= '0;
            r_init_done <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_rd_valid  <= '0;
        end else begin
            r_cfg_err  <= w_accept & ~w_w_ok;
            r_rd_valid <= w_re;
            case (r_state)
                ST_EMPTY, ST_READY: begin
                    if (w_accept && w_w_ok) begin
                        r_w         <= cfg_weight;
                        r_acc       <= '0;
                        r_idx       <= '0;
                        r_init_done <= 1'b0;
                        r_state     <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    r_acc <= w_acc_nxt;
                    r_idx <= r_idx + ADDR_W'(1);
                    if (r_idx == LAST_IDX) begin
                        r_state     <= ST_READY;
                        r_init_done <= 1'b1;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    mod_lut_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (w_we),
        .waddr (r_idx),
        .wdata (r_acc),
        .re    (w_re),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign init_done = r_init_done;
    assign cfg_err   = r_cfg_err;
    assign rd_valid  = r_rd_valid;

endmodule

// File: doc/mod_const_lut.md
MOD_CONST_LUT -- requirements
Module: mod_const_lut

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 5, the table address width (depth 2^ADDR_W).
REQ-002 The module SHALL have parameter DATA_W, default 49, the entry width.
REQ-003 The module SHALL have parameter NUM_CH, default 2, the number of independent read channels.
REQ-004 The module SHALL have parameter MODULUS, default 549824583172097, with MODULUS < 2^DATA_W.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-006 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The module SHALL have port cfg_valid, input, 1 bit: a new weight is offered.
REQ-008 The module SHALL have port cfg_ready, output, 1 bit: a weight can be accepted.
REQ-009 The module SHALL have port cfg_weight, input, DATA_W bits: the weight W.
REQ-010 The module SHALL have port cfg_err, output, 1 bit: a one-cycle pulse when a weight is rejected.
REQ-011 The module SHALL have port init_done, output, 1 bit: the table is valid.
REQ-012 The module SHALL have port rd_en, input, NUM_CH bits: per-channel read request.
REQ-013 The module SHALL have port rd_addr, input, NUM_CH*ADDR_W bits: channel c at [c*ADDR_W +: ADDR_W].
REQ-014 The module SHALL have port rd_data, output, NUM_CH*DATA_W bits: channel c at [c*DATA_W +: DATA_W].
REQ-015 The module SHALL have port rd_valid, output, NUM_CH bits: per-channel read-data valid.

Function
REQ-016 The table SHALL hold entry[i] = (i*W) mod MODULUS for i = 0..2^ADDR_W-1.
REQ-017 The FSM SHALL have exactly three states: EMPTY, FILL, READY.
REQ-018 cfg_ready SHALL be 1 in EMPTY and READY and 0 in FILL.
REQ-019 A weight SHALL be accepted on a rising edge where cfg_valid and cfg_ready are both 1.
REQ-020 If the accepted W >= MODULUS, cfg_err SHALL be 1 for the next cycle only, and the state and table SHALL be unchanged.
REQ-021 If the accepted W < MODULUS, the FSM SHALL latch W, clear the accumulator and the fill index, set init_done to 0 and enter FILL.
REQ-022 In FILL, each cycle SHALL write entry[idx] = acc and then update acc by conditional subtraction: acc = acc+W, minus MODULUS if acc+W >= MODULUS.
REQ-023 acc+W SHALL be computed in DATA_W+1 bits, and no multiplier SHALL be used.
REQ-024 FILL SHALL last exactly 2^ADDR_W cycles; the last write (idx = 2^ADDR_W-1) SHALL move the FSM to READY.
REQ-025 init_done SHALL be 1 in the cycle after the last write.
REQ-026 In READY, if rd_en[c] is 1 at edge N, then after edge N+1 rd_data[c] SHALL equal entry[rd_addr[c]] and rd_valid[c] SHALL be 1 (one-cycle latency).
REQ-027 When rd_en[c] is 0, or the state is not READY, rd_valid[c] SHALL be 0 and rd_data[c] SHALL hold its last value.
REQ-028 All channels SHALL read concurrently; identical addresses on several channels SHALL be legal.
REQ-029 A new weight accepted in READY SHALL drop init_done after that edge; reads presented on that accept edge SHALL still return old-table data.
REQ-030 After reset, the state SHALL be EMPTY and no table contents SHALL be valid.

Reset
REQ-031 On rst_n low, asynchronously: state=EMPTY, init_done=0, cfg_err=0, rd_valid=0, rd_data=0, acc=0, idx=0, latched W=0.
REQ-032 Table storage SHALL NOT be reset.
REQ-033 Reset during FILL SHALL abort the fill and return to EMPTY, with init_done staying 0 until a complete refill.

Structure
REQ-034 The FSM state encoding and a MOD_ADD helper constant or function SHALL live in a shared package, mod_lut_pkg.
REQ-035 The storage SHALL be one sub-module, mod_lut_ram: one write port and NUM_CH registered read ports, with ram_style distributed.
REQ-036 The FSM, accumulator and handshake SHALL remain in mod_const_lut.

Verification
REQ-037 Defaults, W=244589139065832, read addresses 1, 4 and 9 on ch0 -> 244589139065832, 428531973091231, 2003918904100, each one cycle after rd_en.
REQ-038 Accept at edge N -> cfg_ready=0 after edges N..N+31; init_done=1 after edge N+32 and not before; reads during FILL give rd_valid=0.
REQ-039 W=MODULUS -> cfg_err=1 for one cycle, state unchanged, init_done unchanged.
REQ-040 W=0 -> every entry reads 0; W=MODULUS-1 -> entry[2]=MODULUS-2 and entry[31]=MODULUS-31.
REQ-041 rst_n low at FILL cycle 10 -> all outputs 0 at once; a later refill with W=1 -> entry[i]=i for all i.
REQ-042 Both channels reading address 31 while a reconfiguration is accepted on the same edge -> old-table value on both channels, then rd_valid=0 until the refill completes.
